// File: rtl/control_pipeline_if.sv
// control_pipeline_if: ID-stage decode inputs and per-stage control outputs of the control pipeline
interface control_pipeline_if #(parameter int CONTROL_SIZE = 8);
    logic [CONTROL_SIZE-1:0] id_control;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic [1:0] id_branch_src;
    logic [1:0] id_compare_code;
    logic id_branch_taken;
    logic [CONTROL_SIZE-1:0] ex_control;
    logic [4:0] mem_control;
    logic [2:0] wb_control;
    logic [4:0] ex_dest;
    logic [4:0] mem_dest;
    logic [4:0] wb_dest;
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic stall;
    logic flush_if_id;
    modport master (
        output id_control, id_rs, id_rt, id_rd, id_branch_src, id_compare_code, id_branch_taken,
        input ex_control, mem_control, wb_control, ex_dest, mem_dest, wb_dest,
        input forward_a, forward_b, stall, flush_if_id
    );
    modport slave (
        input id_control, id_rs, id_rt, id_rd, id_branch_src, id_compare_code, id_branch_taken,
        output ex_control, mem_control, wb_control, ex_dest, mem_dest, wb_dest,
        output forward_a, forward_b, stall, flush_if_id
    );
endinterface

// File: rtl/control_pipeline.sv
// control_pipeline: carries decoder control through ID/EX, EX/MEM, MEM/WB with forwarding and hazard detection
module control_pipeline #(parameter logic [4:0] REG_RA = 5'd31) (
    input logic clk,
    input logic rst_n,
    control_pipeline_if.slave bus
);
    logic [4:0] id_dest;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic load_use;
    logic branch_hazard;
    logic br_check;
    logic rs_only;

    function automatic logic [1:0] fwd_sel(input logic mw, input logic [4:0] md,
                                           input logic ww, input logic [4:0] wd, input logic [4:0] r);
        return (mw && md != 5'd0 && md == r) ? 2'b01 : (ww && wd != 5'd0 && wd == r) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic is_operand(input logic [4:0] d, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic only_rs);
        return d != 5'd0 && (d == rs || (!only_rs && d == rt));
    endfunction

    assign id_dest = bus.id_control[6] ? (bus.id_control[5] ? 5'd0 : REG_RA)
                                       : (bus.id_control[5] ? bus.id_rt : bus.id_rd);

    // hazard detection, IF/ID flush and EX operand forwarding selects
    always_comb begin
        br_check = bus.id_branch_src == 2'b10 && bus.id_compare_code != 2'b00;
        rs_only = bus.id_compare_code == 2'b11;
        load_use = bus.ex_control[4] && bus.ex_dest != 5'd0 &&
                   (bus.ex_dest == bus.id_rs || bus.ex_dest == bus.id_rt);
        branch_hazard = br_check &&
                        ((bus.ex_control[2] && is_operand(bus.ex_dest, bus.id_rs, bus.id_rt, rs_only)) ||
                         (bus.mem_control[4] && is_operand(bus.mem_dest, bus.id_rs, bus.id_rt, rs_only)));
        bus.stall = load_use || branch_hazard;
        bus.flush_if_id = bus.id_compare_code != 2'b00 && bus.id_branch_taken && !(load_use || branch_hazard);
        bus.forward_a = fwd_sel(bus.mem_control[2], bus.mem_dest, bus.wb_control[2], bus.wb_dest, ex_rs);
        bus.forward_b = fwd_sel(bus.mem_control[2], bus.mem_dest, bus.wb_control[2], bus.wb_dest, ex_rt);
    end

    // advance the pipeline registers; a stall turns the ID/EX capture into a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_control <= '0;
            bus.ex_dest <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            bus.mem_control <= '0;
            bus.mem_dest <= '0;
            bus.wb_control <= '0;
            bus.wb_dest <= '0;
        end else begin
            bus.ex_control <= bus.stall ? '0 : bus.id_control;
            bus.ex_dest <= bus.stall ? 5'd0 : id_dest;
            ex_rs <= bus.stall ? 5'd0 : bus.id_rs;
            ex_rt <= bus.stall ? 5'd0 : bus.id_rt;
            bus.mem_control <= bus.ex_control[4:0];
            bus.mem_dest <= bus.ex_dest;
            bus.wb_control <= bus.mem_control[2:0];
            bus.wb_dest <= bus.mem_dest;
        end
    end
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed scenarios with an instruction-level reference model checked every cycle
module tb_control_pipeline;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    control_pipeline_if bus();
    control_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] c;
        logic [4:0] d;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    instr_t m_ex, m_mem, m_wb;

    function automatic logic [4:0] dest_of(input logic [7:0] c, input logic [4:0] rt, input logic [4:0] rd);
        case (c[6:5])
            2'b00: return rd;
            2'b01: return rt;
            2'b10: return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic branch_reads(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (r == bus.id_rs) return 1'b1;
        return bus.id_compare_code != 2'b11 && r == bus.id_rt;
    endfunction

    function automatic logic m_stall();
        logic lu;
        logic bh;
        lu = m_ex.c[4] && m_ex.d != 5'd0 && (m_ex.d == bus.id_rs || m_ex.d == bus.id_rt);
        bh = bus.id_branch_src == 2'b10 && bus.id_compare_code != 2'b00 &&
             ((m_ex.c[2] && branch_reads(m_ex.d)) || (m_mem.c[4] && branch_reads(m_mem.d)));
        return lu || bh;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        instr_t older [2];
        older[0] = m_mem;
        older[1] = m_wb;
        for (int i = 0; i < 2; i++)
            if (older[i].c[2] && older[i].d != 5'd0 && older[i].d == r) return 2'(i + 1);
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // reference model: instructions move one stage per edge, a stall inserts a bubble
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex <= '0;
            m_mem <= '0;
            m_wb <= '0;
        end else begin
            m_wb <= m_mem;
            m_mem <= m_ex;
            m_ex <= m_stall() ? '0 : instr_t'{c: bus.id_control, d: dest_of(bus.id_control, bus.id_rt, bus.id_rd),
                                              rs: bus.id_rs, rt: bus.id_rt};
        end
    end

    // compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        if (!done) begin
            chk("ex_control", 32'(bus.ex_control), 32'(m_ex.c));
            chk("mem_control", 32'(bus.mem_control), 32'(m_mem.c[4:0]));
            chk("wb_control", 32'(bus.wb_control), 32'(m_wb.c[2:0]));
            chk("ex_dest", 32'(bus.ex_dest), 32'(m_ex.d));
            chk("mem_dest", 32'(bus.mem_dest), 32'(m_mem.d));
            chk("wb_dest", 32'(bus.wb_dest), 32'(m_wb.d));
            chk("forward_a", 32'(bus.forward_a), 32'(m_fwd(m_ex.rs)));
            chk("forward_b", 32'(bus.forward_b), 32'(m_fwd(m_ex.rt)));
            chk("stall", 32'(bus.stall), 32'(m_stall()));
            chk("flush_if_id", 32'(bus.flush_if_id), 32'(bus.id_compare_code != 2'b00 && bus.id_branch_taken && !m_stall()));
        end
    end

    task automatic drive(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [1:0] bs, input logic [1:0] cc, input logic tk);
        bus.id_control = c;
        bus.id_rs = rs;
        bus.id_rt = rt;
        bus.id_rd = rd;
        bus.id_branch_src = bs;
        bus.id_compare_code = cc;
        bus.id_branch_taken = tk;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        drive(8'h00, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        drive(8'hFF, 5'd1, 5'd2, 5'd3, 2'b00, 2'b00, 1'b0);
        chk("rst_ex_control", 32'(bus.ex_control), 32'h0);
        tick();
        tick();
        chk("rst_wb_dest", 32'(bus.wb_dest), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        rst_n = 1'b1;
        drive(8'h21, 5'd1, 5'd3, 5'd3, 2'b00, 2'b00, 1'b0);
        tick();
        chk("add_ex_control", 32'(bus.ex_control), 32'h21);
        chk("add_ex_dest", 32'(bus.ex_dest), 32'd3);
        nops(2);
        chk("add_wb_control", 32'(bus.wb_control), 32'h1);
        chk("add_wb_dest", 32'(bus.wb_dest), 32'd3);
        nops(3);
        drive(8'hB5, 5'd1, 5'd5, 5'd0, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h04, 5'd5, 5'd6, 5'd7, 2'b00, 2'b00, 1'b0);
        chk("lu_stall", 32'(bus.stall), 32'h1);
        tick();
        chk("lu_bubble", 32'(bus.ex_control), 32'h0);
        chk("lu_release", 32'(bus.stall), 32'h0);
        tick();
        chk("lu_issue", 32'(bus.ex_control), 32'h04);
        chk("lu_fwd_a", 32'(bus.forward_a), 32'h2);
        nops(3);
        drive(8'h04, 5'd0, 5'd0, 5'd7, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h04, 5'd0, 5'd0, 5'd7, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h04, 5'd7, 5'd0, 5'd8, 2'b00, 2'b00, 1'b0);
        tick();
        chk("prio_mem", 32'(bus.forward_a), 32'h1);
        nops(3);
        drive(8'h04, 5'd0, 5'd0, 5'd7, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h64, 5'd0, 5'd7, 5'd7, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h04, 5'd7, 5'd0, 5'd8, 2'b00, 2'b00, 1'b0);
        tick();
        chk("prio_wb", 32'(bus.forward_a), 32'h2);
        nops(3);
        drive(8'hA4, 5'd0, 5'd4, 5'd0, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h00, 5'd4, 5'd2, 5'd0, 2'b10, 2'b01, 1'b1);
        chk("alu_br_stall", 32'(bus.stall), 32'h1);
        chk("alu_br_noflush", 32'(bus.flush_if_id), 32'h0);
        tick();
        chk("alu_br_release", 32'(bus.stall), 32'h0);
        chk("alu_br_flush", 32'(bus.flush_if_id), 32'h1);
        nops(0);
        chk("alu_br_flush_end", 32'(bus.flush_if_id), 32'h0);
        nops(3);
        drive(8'hB5, 5'd1, 5'd9, 5'd0, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h00, 5'd3, 5'd9, 5'd0, 2'b10, 2'b10, 1'b1);
        chk("lw_br_stall1", 32'(bus.stall), 32'h1);
        tick();
        chk("lw_br_stall2", 32'(bus.stall), 32'h1);
        chk("lw_br_noflush", 32'(bus.flush_if_id), 32'h0);
        tick();
        chk("lw_br_release", 32'(bus.stall), 32'h0);
        chk("lw_br_flush", 32'(bus.flush_if_id), 32'h1);
        nops(3);
        drive(8'h44, 5'd0, 5'd0, 5'd0, 2'b00, 2'b11, 1'b1);
        chk("jal_stall", 32'(bus.stall), 32'h0);
        chk("jal_flush", 32'(bus.flush_if_id), 32'h1);
        tick();
        chk("jal_dest", 32'(bus.ex_dest), 32'd31);
        nops(2);
        drive(8'h74, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 2'b10, 2'b11, 1'b1);
        chk("zero_dest_stall", 32'(bus.stall), 32'h0);
        chk("zero_dest_flush", 32'(bus.flush_if_id), 32'h1);
        nops(3);
        drive(8'h04, 5'd0, 5'd0, 5'd6, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h00, 5'd1, 5'd6, 5'd0, 2'b10, 2'b11, 1'b1);
        chk("jr_ignores_rt", 32'(bus.stall), 32'h0);
        bus.id_compare_code = 2'b01;
        #1;
        chk("beq_uses_rt", 32'(bus.stall), 32'h1);
        nops(3);
        drive(8'h04, 5'd0, 5'd0, 5'd6, 2'b00, 2'b00, 1'b0);
        tick();
        drive(8'h04, 5'd0, 5'd0, 5'd5, 2'b00, 2'b00, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ex", 32'(bus.ex_control), 32'h0);
        chk("midrst_mem_dest", 32'(bus.mem_dest), 32'h0);
        chk("midrst_wb_dest", 32'(bus.wb_dest), 32'h0);
        nops(1);
        rst_n = 1'b1;
        nops(3);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
